// File: rtl/instruction_fetcher_pkg.sv
// Shared constants and state encoding for the instruction fetcher.
package instruction_fetcher_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/instruction_fetcher.sv
// Fetch stage: owns the PC, looks up the I-cache, refills it from memory on a miss,
// and presents {inst, inst_pc} to the decoder through a one-entry valid/ready register.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  output logic              ic_wr,
  output logic [WORD_W-1:0] ic_addr,
  output logic [WORD_W-1:0] ic_wdata,
  input  logic              ic_hit,
  input  logic [WORD_W-1:0] ic_rdata,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [WORD_W-1:0] mem_data,
  output logic              inst_valid,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] inst_pc,
  input  logic              dec_ready
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] req_addr_q, req_addr_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              inst_valid_q, inst_valid_d;
  logic [WORD_W-1:0] inst_q, inst_d;
  logic [WORD_W-1:0] inst_pc_q, inst_pc_d;
  logic              out_free;

  assign out_free = !inst_valid_q || dec_ready;

  // The refill write lands in the same cycle as mem_done, in both WAIT and DRAIN.
  assign ic_wr    = rdy && mem_done && (state_q != FETCH);
  assign ic_wdata = ic_wr ? mem_data : '0;
  assign ic_addr  = (state_q == FETCH) ? pc_q : req_addr_q;

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;

    if (rdy) begin
      if (inst_valid_q && dec_ready) inst_valid_d = 1'b0;

      if (flush) begin
        // An outstanding refill must still complete, so a pending miss drains instead of aborting.
        pc_d         = flush_pc;
        inst_valid_d = 1'b0;
        if (state_q != FETCH) begin
          if (mem_done) begin
            state_d   = FETCH;
            mem_req_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end
      end else begin
        case (state_q)
          FETCH: begin
            if (ic_hit) begin
              if (out_free) begin
                inst_d       = ic_rdata;
                inst_pc_d    = pc_q;
                inst_valid_d = 1'b1;
                pc_d         = pc_q + 32'd4;
              end
            end else begin
              mem_req_d  = 1'b1;
              mem_addr_d = pc_q;
              req_addr_d = pc_q;
              state_d    = WAIT;
            end
          end
          WAIT, DRAIN: begin
            if (mem_done) begin
              mem_req_d = 1'b0;
              state_d   = FETCH;
            end
          end
          default: state_d = FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= '0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher with a small direct-mapped cache model
// and hand-driven memory responses.
module tb_instruction_fetcher;

  localparam logic [31:0] I4   = 32'h0040_0093;
  localparam logic [31:0] I8   = 32'h0080_0113;
  localparam logic [31:0] I200 = 32'h2000_0193;
  localparam logic [31:0] I204 = 32'h2040_0213;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [31:0] flush_pc;
  logic        ic_wr;
  logic [31:0] ic_addr;
  logic [31:0] ic_wdata;
  logic        ic_hit;
  logic [31:0] ic_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready;

  int vectors;
  int miscompares;

  // Cache model: 256 word lines indexed by addr[9:2], full address kept as tag.
  logic [31:0] c_data [256];
  logic [31:0] c_tag  [256];
  logic        c_vld  [256];
  logic        clr;
  logic        pre_we;
  logic [31:0] pre_addr;
  logic [31:0] pre_data;

  instruction_fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .ic_wr      (ic_wr),
    .ic_addr    (ic_addr),
    .ic_wdata   (ic_wdata),
    .ic_hit     (ic_hit),
    .ic_rdata   (ic_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_done   (mem_done),
    .mem_data   (mem_data),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .dec_ready  (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) c_vld[i] <= 1'b0;
    end else if (pre_we) begin
      c_data[pre_addr[9:2]] <= pre_data;
      c_tag[pre_addr[9:2]]  <= pre_addr;
      c_vld[pre_addr[9:2]]  <= 1'b1;
    end else if (ic_wr) begin
      c_data[ic_addr[9:2]] <= ic_wdata;
      c_tag[ic_addr[9:2]]  <= ic_addr;
      c_vld[ic_addr[9:2]]  <= 1'b1;
    end
  end

  assign ic_hit   = c_vld[ic_addr[9:2]] && (c_tag[ic_addr[9:2]] == ic_addr);
  assign ic_rdata = c_data[ic_addr[9:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic f, input logic [31:0] fpc, input logic md,
                               input logic [31:0] mdata, input logic dr, input logic en);
    flush     = f;
    flush_pc  = fpc;
    mem_done  = md;
    mem_data  = mdata;
    dec_ready = dr;
    rdy       = en;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    tick();
    pre_we   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr         = 1'b1;
    pre_we      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;
    rst         = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_ic_wr", {31'b0, ic_wr}, 32'd0);
    checkOutput("rst_ic_wdata", ic_wdata, 32'h0);
    checkOutput("rst_ic_addr", ic_addr, 32'h0);

    tick();
    clr = 1'b0;
    preload(32'h0000_0004, I4);
    preload(32'h0000_0008, I8);
    preload(32'h0000_0200, I200);
    preload(32'h0000_0204, I204);

    // Cold miss at 0x0; memory answers on the third edge after the request.
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("miss_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("miss_mem_addr", mem_addr, 32'h0);
    checkOutput("miss_inst_valid", {31'b0, inst_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("wait_mem_req", {31'b0, mem_req}, 32'd1);
      checkOutput("wait_ic_addr", ic_addr, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0013, 1'b1, 1'b1);
    #1;
    checkOutput("fill_ic_wr", {31'b0, ic_wr}, 32'd1);
    checkOutput("fill_ic_addr", ic_addr, 32'h0);
    checkOutput("fill_ic_wdata", ic_wdata, 32'h0000_0013);
    tick();
    mem_done = 1'b0;
    checkOutput("refill_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("refill_ic_wr", {31'b0, ic_wr}, 32'd0);
    checkOutput("retry_no_inst_yet", {31'b0, inst_valid}, 32'd0);
    tick();
    checkOutput("retry_inst_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("retry_inst", inst, 32'h0000_0013);
    checkOutput("retry_inst_pc", inst_pc, 32'h0);

    // Decoder stalls for four cycles: output and pc must hold.
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("stall_inst", inst, 32'h0000_0013);
      checkOutput("stall_inst_pc", inst_pc, 32'h0);
      checkOutput("stall_pc", ic_addr, 32'h4);
    end
    dec_ready = 1'b1;
    tick();
    checkOutput("resume_inst", inst, I4);
    checkOutput("resume_inst_pc", inst_pc, 32'h4);
    tick();
    checkOutput("stream_inst", inst, I8);
    checkOutput("stream_inst_pc", inst_pc, 32'h8);
    checkOutput("stream_mem_req", {31'b0, mem_req}, 32'd0);

    // Miss at 0x100, then flush to cached 0x200 while it is pending.
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    flush = 1'b0;
    checkOutput("flushF_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("flushF_pc", ic_addr, 32'h100);
    tick();
    checkOutput("m100_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("m100_mem_addr", mem_addr, 32'h100);
    applyStimulus(1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    flush = 1'b0;
    checkOutput("drain_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("drain_mem_addr", mem_addr, 32'h100);
    checkOutput("drain_ic_addr", ic_addr, 32'h100);
    tick();
    checkOutput("drain_no_emit", {31'b0, inst_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_100D, 1'b1, 1'b1);
    #1;
    checkOutput("drain_ic_wr", {31'b0, ic_wr}, 32'd1);
    checkOutput("drain_wr_addr", ic_addr, 32'h100);
    checkOutput("drain_wr_data", ic_wdata, 32'h0000_100D);
    tick();
    mem_done = 1'b0;
    checkOutput("postdrain_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("postdrain_no_emit", {31'b0, inst_valid}, 32'd0);
    checkOutput("postdrain_pc", ic_addr, 32'h200);
    tick();
    checkOutput("redir_inst", inst, I200);
    checkOutput("redir_inst_pc", inst_pc, 32'h200);
    tick();
    checkOutput("redir2_inst_pc", inst_pc, 32'h204);

    // The drained word must now be cached at 0x100.
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    flush = 1'b0;
    checkOutput("flush100_inst_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    checkOutput("hit100_inst", inst, 32'h0000_100D);
    checkOutput("hit100_inst_pc", inst_pc, 32'h100);
    checkOutput("hit100_mem_req", {31'b0, mem_req}, 32'd0);
    tick();
    checkOutput("m104_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("m104_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("m104_mem_addr", mem_addr, 32'h104);

    // Flush and mem_done together while WAIT.
    applyStimulus(1'b1, 32'h0000_0008, 1'b1, 32'h0000_104D, 1'b1, 1'b1);
    #1;
    checkOutput("fdone_ic_wr", {31'b0, ic_wr}, 32'd1);
    checkOutput("fdone_ic_addr", ic_addr, 32'h104);
    checkOutput("fdone_ic_wdata", ic_wdata, 32'h0000_104D);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("fdone_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("fdone_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("fdone_pc", ic_addr, 32'h8);
    tick();
    checkOutput("fdone_hit_inst", inst, I8);
    checkOutput("fdone_hit_inst_pc", inst_pc, 32'h8);
    dec_ready = 1'b0;
    tick();
    checkOutput("mC_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("mC_mem_addr", mem_addr, 32'hC);
    checkOutput("mC_inst_valid", {31'b0, inst_valid}, 32'd1);

    // rdy low for five edges: mem_done is lost and nothing moves.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    #1;
    checkOutput("frz_ic_wr", {31'b0, ic_wr}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      mem_done = 1'b0;
      checkOutput("frz_inst_valid", {31'b0, inst_valid}, 32'd1);
      checkOutput("frz_inst", inst, I8);
      checkOutput("frz_mem_req", {31'b0, mem_req}, 32'd1);
      checkOutput("frz_ic_addr", ic_addr, 32'hC);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("lost_done_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("lost_done_inst_valid", {31'b0, inst_valid}, 32'd1);

    // Asynchronous reset mid-WAIT, between clock edges.
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("arst_pc", ic_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
